line_mem_arbiter: RTL and testbench
===================================

Name: line_mem_arbiter

Overview:
N-channel arbiter and burst adaptor between line-granular cache clients (L1 instruction/data, L2) and burst-oriented physical memory. It is the generalised successor to the fixed two-requester/256-bit-line/64-bit-burst memory path. Channel count, line width, burst width and address width are all parametrised. It round-robins whole-line read/write requests and serialises each into LINE_W/BURST_W memory beats.

Parameters:
NUM_CH, 2, number of requesting channels (>=1)
LINE_W, 256, line width in bits; integer multiple of BURST_W
BURST_W, 64, memory beat width in bits
ADDR_W, 32, address width
(derived) BEATS = LINE_W/BURST_W; OFS = log2(LINE_W/8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ch_read  in  NUM_CH  per-channel line read request, held until ch_resp
ch_write  in  NUM_CH  per-channel line write request, held until ch_resp
ch_addr  in  NUM_CH*ADDR_W  flattened per-channel byte address; channel k at [k*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*LINE_W  flattened per-channel write line
ch_rdata  out  LINE_W  read line, shared by all channels, valid with ch_resp
ch_resp  out  NUM_CH  one-cycle completion pulse to the granted channel
mem_addr  out  ADDR_W  line-aligned burst address
mem_read  out  1  burst read request
mem_write  out  1  burst write request
mem_wdata  out  BURST_W  current write beat
mem_rdata  in  BURST_W  current read beat, valid with mem_resp
mem_resp  in  1  per-beat acknowledge

Behaviour:
- Reset (async, active-high): state IDLE, RR pointer 0, beat index 0; all outputs 0 (ch_rdata, ch_resp, mem_*).
- States: IDLE -> RD_BURST | WR_BURST -> DONE -> IDLE.
- IDLE: request of channel k = ch_read[k] | ch_write[k]. If any request is pending, grant the first requesting channel at or after RR pointer (wrapping modulo NUM_CH). On the grant edge, register:
  - the grant index;
  - mem_addr = ch_addr[k] with the low OFS bits zeroed;
  - for writes, ch_wdata[k] into a line buffer.
- Request type: write takes precedence if both ch_read[k] and ch_write[k] are asserted (illegal but defined).
- RD_BURST: mem_read=1 from the cycle after the grant.
  - Each mem_resp stores mem_rdata into line slot [idx*BURST_W +: BURST_W] and increments idx.
  - After beat BEATS-1, go to DONE and drop mem_read.
- WR_BURST: mem_write=1; mem_wdata = buffer[idx*BURST_W +: BURST_W], low beat first.
  - idx advances on each mem_resp; after beat BEATS-1, go to DONE.
- DONE (one cycle):
  - ch_resp[grant]=1 and all other ch_resp bits 0.
  - ch_rdata presents the assembled line (reads) and holds it stable until the next read burst overwrites it.
  - RR pointer = (grant+1) mod NUM_CH.
  - Return to IDLE.
- Latency: request seen at IDLE edge t -> mem_read/mem_write high at t+1. ch_resp rises the cycle after the last mem_resp. Minimum request-to-response is BEATS+2 cycles with single-cycle memory.
- mem_read and mem_write are never high together. Both are 0 in IDLE and DONE.
- The client deasserts its request in the cycle ch_resp is seen. A request still high in IDLE after DONE is a new request.
- mem_resp in IDLE/DONE is ignored.
- Requests arriving mid-burst wait; they are never dropped.
- BEATS=1: single-beat passthrough, same FSM.
- NUM_CH=1: RR pointer is a constant 0.
- Reset mid-burst: immediate return to IDLE with all outputs 0; the in-flight burst is abandoned and no ch_resp is issued.

Optional Feature:
LINE_ARB_FIXED_PRIO_EN:
- Defined: fixed priority replaces round-robin; the lowest-index requesting channel always wins and the RR pointer logic is removed.
- Undefined (default): round-robin as above.

Test Plan:
1. Single read, defaults: ch_read[0]=1, addr 0x0000_1234; memory returns beats 0x11..,0x22..,0x33..,0x44.. -> mem_addr=0x0000_1220, 4 mem_resp, ch_resp[0] one pulse, ch_rdata={0x44..,0x33..,0x22..,0x11..}.
2. Write line 0x...DDDD_CCCC_BBBB_AAAA (64-bit beats A,B,C,D) on ch 1, addr 0x40 -> mem_write with mem_wdata A,B,C,D on successive resps, mem_read never high, ch_resp[1] pulse.
3. Contention: ch0 read and ch1 write held continuously from reset -> grants alternate 0,1,0,1; with LINE_ARB_FIXED_PRIO_EN, ch0 is served on every re-request while ch1 starves until ch0 idles.
4. Memory stalls: mem_resp gaps of 0,3,7,1 cycles between beats -> outputs held, correct line assembled, ch_resp only after the 4th beat.
5. Reset asserted after beat 2 of a read -> same-cycle async clear of mem_read and ch_resp. After release with a new ch_read[1] at 0x80, a full clean burst completes.
6. NUM_CH=4, BURST_W=32 (BEATS=8): all four channels request simultaneously -> served in order 0,1,2,3, 8 beats each, no simultaneous mem_read/mem_write.

Source files
------------

// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: N-channel line arbiter that serialises whole-line requests into memory bursts.
// Define LINE_ARB_FIXED_PRIO_EN to make the lowest-index channel win instead of round-robin.
module line_mem_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_read,
   input  logic [NUM_CH-1:0]          ch_write,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
   input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
   output logic [LINE_W-1:0]          ch_rdata,
   output logic [NUM_CH-1:0]          ch_resp,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic [BURST_W-1:0]         mem_wdata,
   input  logic [BURST_W-1:0]         mem_rdata,
   input  logic                       mem_resp
);
   localparam int BEATS = LINE_W / BURST_W;
   localparam int OFS   = $clog2(LINE_W / 8);
   localparam int CW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

   state_t                        state_q, state_d;
   logic [CW-1:0]                 grant_q, grant_d, pick;
   logic [BW-1:0]                 idx_q, idx_d;
   logic [ADDR_W-1:0]             mem_addr_q;
   logic [BEATS-1:0][BURST_W-1:0] wbuf_q, rdata_q;
   logic [NUM_CH-1:0][ADDR_W-1:0] addr_v;
   logic [NUM_CH-1:0][LINE_W-1:0] wdata_v;
   logic [NUM_CH-1:0]             req;
   logic                          found, last;

   assign addr_v   = ch_addr;
   assign wdata_v  = ch_wdata;
   assign req      = ch_read | ch_write;
   assign last     = idx_q == BW'(BEATS - 1);
   assign ch_rdata = rdata_q;
   assign mem_addr = mem_addr_q;

`ifdef LINE_ARB_FIXED_PRIO_EN
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (req[CW'(i)]) begin
            pick  = CW'(i);
            found = 1'b1;
         end
   end
`else
   logic [CW-1:0] rr_q, rr_d;
   int            rot;

   assign rr_d = grant_q == CW'(NUM_CH - 1) ? '0 : grant_q + 1'b1;

   // Scan channels starting at the pointer, wrapping without a modulo operator.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      rot   = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         rot = int'(rr_q) + i;
         rot = rot >= NUM_CH ? rot - NUM_CH : rot;
         if (!found && req[CW'(rot)]) begin
            pick  = CW'(rot);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) rr_q <= '0;
      else if (state_q == DONE) rr_q <= rr_d;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      mem_read  = state_q == RD_BURST;
      mem_write = state_q == WR_BURST;
      mem_wdata = mem_write ? wbuf_q[idx_q] : '0;
      ch_resp   = state_q == DONE ? NUM_CH'(1) << grant_q : '0;
      case (state_q)
         IDLE: if (found) begin
            state_d = ch_write[pick] ? WR_BURST : RD_BURST;
            grant_d = pick;
            idx_d   = '0;
         end
         RD_BURST, WR_BURST: if (mem_resp) begin
            state_d = last ? DONE : state_q;
            idx_d   = last ? '0 : idx_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else state_q <= state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q    <= '0;
         idx_q      <= '0;
         mem_addr_q <= '0;
         wbuf_q     <= '0;
         rdata_q    <= '0;
      end else begin
         grant_q <= grant_d;
         idx_q   <= idx_d;
         if (state_q == IDLE && found) begin
            mem_addr_q <= addr_v[pick] & ~ADDR_W'((1 << OFS) - 1);
            if (ch_write[pick]) wbuf_q <= wdata_v[pick];
         end
         // The assembled line stays visible until a later read overwrites it.
         if (state_q == RD_BURST && mem_resp) rdata_q[idx_q] <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb_line_mem_arbiter: directed tests for line_mem_arbiter against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_line_mem_arbiter;
   localparam int NC = 2, LW = 256, BWD = 64, AW = 32, NB = LW / BWD;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic [NC-1:0]    ch_read, ch_write, ch_resp;
   logic [NC*AW-1:0] ch_addr;
   logic [NC*LW-1:0] ch_wdata;
   logic [LW-1:0]    ch_rdata;
   logic [AW-1:0]    mem_addr;
   logic             mem_read, mem_write, mem_resp;
   logic [BWD-1:0]   mem_wdata, mem_rdata;

   logic [3:0]    ch_read4, ch_write4, ch_resp4;
   logic [127:0]  ch_addr4;
   logic [1023:0] ch_wdata4;
   logic [255:0]  ch_rdata4;
   logic [31:0]   mem_addr4, mem_wdata4, mem_rdata4;
   logic          mem_read4, mem_write4, mem_resp4;

   line_mem_arbiter dut (
      .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr),
      .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_resp(ch_resp), .mem_addr(mem_addr),
      .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp));

   line_mem_arbiter #(.NUM_CH(4), .BURST_W(32)) dut4 (
      .clk(clk), .rst(rst), .ch_read(ch_read4), .ch_write(ch_write4), .ch_addr(ch_addr4),
      .ch_wdata(ch_wdata4), .ch_rdata(ch_rdata4), .ch_resp(ch_resp4), .mem_addr(mem_addr4),
      .mem_read(mem_read4), .mem_write(mem_write4), .mem_wdata(mem_wdata4),
      .mem_rdata(mem_rdata4), .mem_resp(mem_resp4));

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: programmable gaps before each beat, optional stray acks while idle.
   int             gaps[NB];
   logic [BWD-1:0] rd_pat[NB];
   bit             junk;
   int             mbeat, gcnt, rbeats, rdcyc;
   logic [BWD-1:0] wlog[$];

   initial begin
      mem_resp = 1'b0; mem_rdata = '0; mbeat = 0; gcnt = 0; rbeats = 0; rdcyc = 0;
      forever begin
         @(negedge clk);
         mem_resp = 1'b0;
         if (mem_read) rdcyc++;
         if (rst || !(mem_read || mem_write)) begin
            mbeat = 0; gcnt = 0;
            mem_resp = junk && !rst;
            if (mem_resp) mem_rdata = '1;
         end else if (gcnt < gaps[mbeat % NB]) gcnt++;
         else begin
            mem_resp = 1'b1;
            mem_rdata = rd_pat[mbeat % NB];
            if (mem_write) wlog.push_back(mem_wdata);
            gcnt = 0; mbeat++; rbeats++;
         end
      end
   end

   // Behavioural model: 0 idle, 1 burst, 2 response; compared after every rising edge.
   int            m_st = 0, m_g = 0, m_rr = 0, m_beat = 0;
   bit            m_wr = 0;
   logic [AW-1:0] m_addr = '0;
   logic [LW-1:0] m_wl = '0, m_rd = '0;

   initial begin
      int k;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            m_st = 0; m_g = 0; m_rr = 0; m_beat = 0; m_addr = '0; m_rd = '0;
         end else if (m_st == 0) begin
            k = -1;
            for (int i = 0; i < NC; i++)
               if (k < 0 && (ch_read[(m_rr + i) % NC] || ch_write[(m_rr + i) % NC])) k = (m_rr + i) % NC;
            if (k >= 0) begin
               m_g = k; m_wr = ch_write[k]; m_beat = 0; m_st = 1;
               m_addr = ch_addr[k*AW +: AW] & ~32'h1f;
               m_wl = ch_wdata[k*LW +: LW];
            end
         end else if (m_st == 1) begin
            if (mem_resp) begin
               if (!m_wr) m_rd[m_beat*BWD +: BWD] = mem_rdata;
               m_beat++;
               if (m_beat == NB) m_st = 2;
            end
         end else begin
`ifndef LINE_ARB_FIXED_PRIO_EN
            m_rr = (m_g + 1) % NC;
`endif
            m_st = 0;
         end
         chk("mem_read", mem_read, m_st == 1 && !m_wr);
         chk("mem_write", mem_write, m_st == 1 && m_wr);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, (m_st == 1 && m_wr) ? m_wl[(m_beat % NB)*BWD +: BWD] : 64'h0);
         chk("ch_resp", ch_resp, m_st == 2 ? 2'(1 << m_g) : 2'b00);
         chk("ch_rdata", ch_rdata, m_rd);
      end
   end

   // Monitor for the 4-channel, 8-beat instance.
   int g4[$], b4[$];
   bit w4[$];
   int bcnt4 = 0;
   bit wseen4 = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("t6_excl", mem_read4 && mem_write4, 1'b0);
            if ((mem_read4 || mem_write4) && mem_resp4) bcnt4++;
            if (mem_write4) wseen4 = 1;
            if (ch_resp4 != 0) begin
               g4.push_back($clog2(ch_resp4)); b4.push_back(bcnt4); w4.push_back(wseen4);
               bcnt4 = 0; wseen4 = 0;
            end
         end
      end
   end

   task automatic req_wait(input int ch, input bit wr, input logic [AW-1:0] addr,
                           input logic [LW-1:0] wd, output int cyc);
      @(negedge clk);
      ch_addr[ch*AW +: AW] = addr;
      ch_wdata[ch*LW +: LW] = wd;
      if (wr) ch_write[ch] = 1'b1;
      else ch_read[ch] = 1'b1;
      cyc = 1;
      while (!ch_resp[ch] && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      if (!ch_resp[ch]) begin
         checks++; errors++;
         $display("FAIL timeout: ch%0d got no ch_resp within %0d cycles", ch, cyc);
      end
      ch_read[ch] = 1'b0;
      ch_write[ch] = 1'b0;
   endtask

   localparam logic [LW-1:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

   initial begin
      int cyc, g3[$], exp3[4];
      bit hit;
      logic [BWD-1:0] wexp[NB];
      ch_read = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0; junk = 0;
      ch_read4 = '0; ch_write4 = '0; ch_addr4 = '0; ch_wdata4 = '0;
      mem_resp4 = 1'b1; mem_rdata4 = 32'hC0DE_0000;
      gaps = '{0, 0, 0, 0};
      rd_pat = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      repeat (3) @(negedge clk);
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_ch_resp", ch_resp, 2'b00);
      chk("rst_ch_rdata", ch_rdata, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      rst = 0;

      junk = 1; rbeats = 0;
      req_wait(0, 0, 32'h0000_1234, '0, cyc);
      chk("t1_latency", cyc, NB + 2);
      chk("t1_rdata", ch_rdata, LINE_A);
      chk("t1_addr", mem_addr, 32'h0000_1220);
      chk("t1_beats", rbeats, 4);
      @(negedge clk);
      chk("t1_pulse", ch_resp, 2'b00);
      junk = 0;

      wlog.delete(); rdcyc = 0;
      wexp = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
      req_wait(1, 1, 32'h40, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, cyc);
      chk("t2_latency", cyc, NB + 2);
      chk("t2_nbeats", wlog.size(), 4);
      for (int i = 0; i < NB; i++) chk("t2_wbeat", wlog.size() > i ? wlog[i] : 64'h0, wexp[i]);
      chk("t2_no_read", rdcyc, 0);
      chk("t2_addr", mem_addr, 32'h40);
      chk("t2_rdata_held", ch_rdata, LINE_A);
      @(negedge clk);
      chk("t2_pulse", ch_resp, 2'b00);

`ifdef LINE_ARB_FIXED_PRIO_EN
      exp3 = '{0, 0, 0, 0};
`else
      exp3 = '{0, 1, 0, 1};
`endif
      ch_addr[0 +: AW] = 32'h100; ch_addr[AW +: AW] = 32'h200;
      ch_wdata[LW +: LW] = {4{64'h0123_4567_89AB_CDEF}};
      ch_read[0] = 1; ch_write[1] = 1;
      for (int c = 0; c < 200 && g3.size() < 4; c++) begin
         @(negedge clk);
         if (ch_resp != 0) g3.push_back(ch_resp[1] ? 1 : 0);
      end
      ch_read = '0; ch_write = '0;
      chk("t3_ngrants", g3.size(), 4);
      for (int i = 0; i < 4; i++) chk("t3_grant", g3.size() > i ? g3[i] : -1, exp3[i]);
      repeat (2) @(negedge clk);

      gaps = '{0, 3, 7, 1};
      rd_pat = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
      req_wait(0, 0, 32'h0000_0FFF, '0, cyc);
      chk("t4_latency", cyc, 17);
      chk("t4_rdata", ch_rdata, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
      chk("t4_addr", mem_addr, 32'h0000_0FE0);
      @(negedge clk);
      chk("t4_pulse", ch_resp, 2'b00);
      gaps = '{0, 0, 0, 0};
      rd_pat = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};

      @(negedge clk);
      ch_addr[0 +: AW] = 32'h300; ch_read[0] = 1;
      hit = 0;
      for (int c = 0; c < 50 && !hit; c++) begin
         @(posedge clk); #2;
         hit = m_st == 1 && m_beat == 2;
      end
      if (!hit) begin
         checks++; errors++;
         $display("FAIL t5_wait: second beat not reached, model state %0d beat %0d", m_st, m_beat);
      end
      chk("t5_pre_read", mem_read, 1'b1);
      #1 rst = 1;
      #1;
      chk("t5_rst_read", mem_read, 1'b0);
      chk("t5_rst_write", mem_write, 1'b0);
      chk("t5_rst_resp", ch_resp, 2'b00);
      chk("t5_rst_addr", mem_addr, '0);
      chk("t5_rst_rdata", ch_rdata, '0);
      @(negedge clk);
      ch_read[0] = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      req_wait(1, 0, 32'h80, '0, cyc);
      chk("t5_latency", cyc, NB + 2);
      chk("t5_resp", ch_resp, 2'b10);
      chk("t5_rdata", ch_rdata, LINE_A);
      chk("t5_addr", mem_addr, 32'h80);
      @(negedge clk);
      chk("t5_pulse", ch_resp, 2'b00);

      g4.delete(); b4.delete(); w4.delete();
      for (int i = 0; i < 4; i++) ch_addr4[i*32 +: 32] = 32'h1000 * (i + 1);
      ch_wdata4 = {32{32'h5A5A_0F0F}};
      ch_read4 = 4'b1011; ch_write4 = 4'b0100;
      for (int c = 0; c < 400 && (ch_read4 | ch_write4) != 0; c++) begin
         @(negedge clk);
         ch_read4 &= ~ch_resp4;
         ch_write4 &= ~ch_resp4;
      end
      chk("t6_drained", ch_read4 | ch_write4, 4'b0000);
      repeat (2) @(negedge clk);
      chk("t6_ngrants", g4.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t6_order", g4.size() > i ? g4[i] : -1, i);
         chk("t6_beats", b4.size() > i ? b4[i] : -1, 8);
         chk("t6_type", w4.size() > i ? w4[i] : 1'bx, i == 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
